regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_if.sv | 16 +
 rtl/regfile_writeback.sv | 92 +++++++++
 tb/tb_regfile_writeback.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// MEM-to-WB bus: the retiring instruction's control, destination and both candidate results.
interface regfile_writeback_if;
    logic        mem_valid;
    logic        mem_regwrite;
    logic        mem_memtoreg;
    logic [4:0]  mem_rd;
    logic [31:0] mem_aluout;
    logic [31:0] mem_readdata;

    modport master (
        output mem_valid, mem_regwrite, mem_memtoreg, mem_rd, mem_aluout, mem_readdata
    );
    modport slave (
        input  mem_valid, mem_regwrite, mem_memtoreg, mem_rd, mem_aluout, mem_readdata
    );
endinterface

// File: rtl/regfile_writeback.sv
// WB pipeline register with a write-once register-file port and a 2-bit-per-GPR pending-write scoreboard.
// MEM -> write port is 1 cycle; stall holds the entry, flush kills it and clears the scoreboard.
module regfile_writeback (
    input  logic                clk,
    input  logic                reset,
    regfile_writeback_if.slave  mem,
    input  logic                stall,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rd,
    input  logic [4:0]          rs,
    input  logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [31:0]         writedata,
    output logic                regwrite,
    output logic                hazard_rs,
    output logic                hazard_rt,
    output logic                sb_overflow
);

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic [4:0]  rd;
        logic [31:0] aluout;
        logic [31:0] readdata;
    } wb_t;

    wb_t         wb;
    logic        wb_done;
    logic [1:0]  cnt [32];
    logic [31:1] inc_vec;
    logic [31:1] dec_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb      <= '0;
            wb_done <= 1'b0;
        end else if (flush) begin
            wb.valid <= 1'b0;
            wb_done  <= 1'b0;
        end else if (!stall) begin
            wb.valid    <= mem.mem_valid;
            wb.regwrite <= mem.mem_regwrite;
            wb.memtoreg <= mem.mem_memtoreg;
            wb.rd       <= mem.mem_rd;
            wb.aluout   <= mem.mem_aluout;
            wb.readdata <= mem.mem_readdata;
            wb_done     <= 1'b0;
        end else if (regwrite) begin
            // a held entry must not rewrite the register file on later stalled cycles
            wb_done <= 1'b1;
        end
    end

    assign rd        = wb.rd;
    assign writedata = wb.memtoreg ? wb.readdata : wb.aluout;
    assign regwrite  = wb.valid & wb.regwrite & (wb.rd != 5'd0) & ~wb_done;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < 32; i++) begin
            inc_vec[i] = issue_valid & (issue_rd == 5'(i));
            dec_vec[i] = regwrite & (wb.rd == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
            sb_overflow <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
        end else begin
            // issue and retire of the same index cancel; counters saturate at both ends
            for (int i = 1; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (cnt[i] == 2'd3) sb_overflow <= 1'b1;
                    else                cnt[i] <= cnt[i] + 2'd1;
                end else if (dec_vec[i] && !inc_vec[i] && cnt[i] != 2'd0) begin
                    cnt[i] <= cnt[i] - 2'd1;
                end
            end
        end
    end

    assign hazard_rs = (rs != 5'd0) & (cnt[rs] != 2'd0);
    assign hazard_rt = (rt != 5'd0) & (cnt[rt] != 2'd0);

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a transaction-level reference model and literal spot checks.
module tb_regfile_writeback;

    logic        clk;
    logic        reset;
    logic        stall, flush, issue_valid;
    logic [4:0]  issue_rd, rs, rt;
    logic [4:0]  rd;
    logic [31:0] writedata;
    logic        regwrite, hazard_rs, hazard_rt, sb_overflow;

    regfile_writeback_if mif ();

    regfile_writeback dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (mif.slave),
        .stall       (stall),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .writedata   (writedata),
        .regwrite    (regwrite),
        .hazard_rs   (hazard_rs),
        .hazard_rt   (hazard_rt),
        .sb_overflow (sb_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else             n_pass++;
    endtask

    // Reference model: the entry in WB, whether it has already been written, and pending-write counts.
    bit          m_valid, m_regw, m_m2r, m_written, m_ovf;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdd;
    int          m_cnt [32];
    bit          m_ret, m_iss;
    int          m_ri, m_ii;

    function automatic bit m_write();
        return m_valid && m_regw && (m_rd != 0) && !m_written;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 0; m_regw = 0; m_m2r = 0; m_written = 0; m_ovf = 0;
            m_rd = '0; m_alu = '0; m_rdd = '0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
        end else begin
            m_ret = m_write();
            m_ri  = int'(m_rd);
            m_iss = issue_valid && (issue_rd != 0);
            m_ii  = int'(issue_rd);
            if (flush) begin
                m_valid   = 0;
                m_written = 0;
                foreach (m_cnt[k]) m_cnt[k] = 0;
            end else begin
                if (!(m_iss && m_ret && m_ii == m_ri)) begin
                    if (m_iss) begin
                        if (m_cnt[m_ii] == 3) m_ovf = 1;
                        else                  m_cnt[m_ii] = m_cnt[m_ii] + 1;
                    end
                    if (m_ret && m_cnt[m_ri] > 0) m_cnt[m_ri] = m_cnt[m_ri] - 1;
                end
                if (!stall) begin
                    m_valid = mif.mem_valid; m_regw = mif.mem_regwrite; m_m2r = mif.mem_memtoreg;
                    m_rd = mif.mem_rd; m_alu = mif.mem_aluout; m_rdd = mif.mem_readdata;
                    m_written = 0;
                end else if (m_ret) begin
                    m_written = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_rd",        32'(rd),          32'(m_rd));
            check("m_writedata", writedata,        m_m2r ? m_rdd : m_alu);
            check("m_regwrite",  32'(regwrite),    32'(m_write()));
            check("m_hazard_rs", 32'(hazard_rs),   32'((rs != 0) && (m_cnt[rs] != 0)));
            check("m_hazard_rt", 32'(hazard_rt),   32'((rt != 0) && (m_cnt[rt] != 0)));
            check("m_overflow",  32'(sb_overflow), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_mem(input bit v, input bit w, input bit m2r, input logic [4:0] d,
                           input logic [31:0] alu, input logic [31:0] rdd);
        mif.mem_valid = v; mif.mem_regwrite = w; mif.mem_memtoreg = m2r;
        mif.mem_rd = d; mif.mem_aluout = alu; mif.mem_readdata = rdd;
    endtask

    initial begin
        reset = 1'b0;
        stall = 0; flush = 0; issue_valid = 0; issue_rd = '0; rs = '0; rt = '0;
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_rd",       32'(rd),          32'h0);
        check("rst_wdata",    writedata,        32'h0);
        check("rst_regwrite", 32'(regwrite),    32'h0);
        check("rst_ovf",      32'(sb_overflow), 32'h0);
        reset  = 1'b1;
        chk_en = 1;
        tick();

        // ALU writeback: exactly one cycle of write
        set_mem(1, 1, 0, 5'd5, 32'h0000_00A5, 32'h1234_5678);
        tick();
        check("alu_regwrite", 32'(regwrite), 32'h1);
        check("alu_rd",       32'(rd),       32'h5);
        check("alu_wdata",    writedata,     32'h0000_00A5);
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        check("alu_one_shot", 32'(regwrite), 32'h0);

        // stalled load is written once, data held
        set_mem(1, 1, 1, 5'd9, 32'h0000_0055, 32'hDEAD_BEEF);
        tick();
        check("ld_regwrite", 32'(regwrite), 32'h1);
        check("ld_wdata",    writedata,     32'hDEAD_BEEF);
        stall = 1;
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ld_stall_nowr",  32'(regwrite), 32'h0);
            check("ld_stall_wdata", writedata,     32'hDEAD_BEEF);
        end
        stall = 0;
        tick();

        // hazard on 7 until it retires; rs=0 never hazards
        issue_valid = 1; issue_rd = 5'd7; rs = 5'd7; rt = 5'd0;
        tick();
        issue_valid = 0;
        check("haz7_set", 32'(hazard_rs), 32'h1);
        check("haz_rt0",  32'(hazard_rt), 32'h0);
        set_mem(1, 1, 0, 5'd7, 32'h77, 32'h0);
        tick();
        check("haz7_during_wr", 32'(hazard_rs), 32'h1);
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        check("haz7_clear", 32'(hazard_rs), 32'h0);

        // saturation and overflow on GPR 3
        rs = 5'd3; issue_valid = 1; issue_rd = 5'd3;
        repeat (4) tick();
        issue_valid = 0;
        check("ovf_set",  32'(sb_overflow), 32'h1);
        check("haz3_sat", 32'(hazard_rs),   32'h1);
        set_mem(1, 1, 0, 5'd3, 32'h33, 32'h0);
        tick();
        issue_valid = 1;
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        issue_valid = 0;
        // three back-to-back retires must be needed to drain a count of 3
        set_mem(1, 1, 0, 5'd3, 32'h33, 32'h0);
        tick();
        tick();
        check("haz3_after1", 32'(hazard_rs), 32'h1);
        tick();
        check("haz3_after2", 32'(hazard_rs), 32'h1);
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        check("haz3_after3", 32'(hazard_rs), 32'h0);

        // retire at count 0 must not wrap
        rs = 5'd11;
        set_mem(1, 1, 0, 5'd11, 32'hB, 32'h0);
        tick();
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        check("nowrap11", 32'(hazard_rs), 32'h0);

        // flush beats stall, kills pending rd=4 and clears scoreboard
        rs = 5'd4; rt = 5'd7; issue_valid = 1; issue_rd = 5'd7;
        tick();
        issue_rd = 5'd4;
        set_mem(1, 1, 0, 5'd4, 32'h44, 32'h0);
        tick();
        check("fl_pre_haz", 32'(hazard_rs), 32'h1);
        flush = 1; stall = 1;
        tick();
        flush = 0; stall = 0; issue_valid = 0;
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("fl_regwrite", 32'(regwrite),  32'h0);
        check("fl_haz_rs",   32'(hazard_rs), 32'h0);
        check("fl_haz_rt",   32'(hazard_rt), 32'h0);
        tick();

        // asynchronous reset mid-write
        set_mem(1, 1, 0, 5'd6, 32'h66, 32'h0);
        tick();
        check("ar_pre_wr", 32'(regwrite), 32'h1);
        #1 reset = 1'b0;
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        check("ar_regwrite", 32'(regwrite),    32'h0);
        check("ar_rd",       32'(rd),          32'h0);
        check("ar_wdata",    writedata,        32'h0);
        check("ar_ovf",      32'(sb_overflow), 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_wr", 32'(regwrite), 32'h0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
